// File: rtl/seg_scan_driver.sv
// Four-digit common-anode 7-segment scanner with per-slot blanking and
// frame-level shadow latching of the digit patterns and enables.
module seg_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_d0,
  input  logic [6:0] seg_d1,
  input  logic [6:0] seg_d2,
  input  logic [6:0] seg_d3,
  input  logic [3:0] digit_en,
  input  logic       lamp_test,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0]   cnt, cnt_nxt;
  logic [1:0]      idx, idx_nxt;
  logic [3:0][6:0] sh, sh_nxt;
  logic [3:0]      sh_en, sh_en_nxt;
  logic [3:0]      an_nxt;
  logic [6:0]      seg_nxt;
  logic            latch;

  // Outputs are derived from the post-edge slot position and the post-edge
  // shadow contents, so a freshly latched frame is usable in the same cycle.
  always_comb begin
    latch = (cnt == '0) && (idx == 2'd0);
    if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      idx_nxt = idx + 2'd1;
    end else begin
      cnt_nxt = cnt + CW'(1);
      idx_nxt = idx;
    end
    sh_nxt    = latch ? {seg_d3, seg_d2, seg_d1, seg_d0} : sh;
    sh_en_nxt = latch ? digit_en : sh_en;
    an_nxt    = 4'hF;
    seg_nxt   = 7'h7F;
    if ((cnt_nxt >= BLANK_END) && sh_en_nxt[idx_nxt]) begin
      an_nxt  = ~(4'b0001 << idx_nxt);
      seg_nxt = lamp_test ? 7'h00 : sh_nxt[idx_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= 2'd0;
      sh          <= {4{7'h7F}};
      sh_en       <= 4'h0;
      an          <= 4'hF;
      seg         <= 7'h7F;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      sh          <= sh_nxt;
      sh_en       <= sh_en_nxt;
      an          <= an_nxt;
      seg         <= seg_nxt;
      frame_start <= latch;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with REFRESH_DIV=8, BLANK_CYCLES=2:
// every cycle is checked against a frame-position model, plus literal spot checks.
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_d0, seg_d1, seg_d2, seg_d3;
  logic [3:0] digit_en;
  logic       lamp_test;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_start;

  int total = 0;
  int bad   = 0;

  // Expected-state model: pos = idx*8 + cnt after the most recent edge.
  int         pos = 0;
  logic [6:0] m_sh [4];
  logic [3:0] m_en;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_fs;

  seg_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .seg_d0(seg_d0), .seg_d1(seg_d1), .seg_d2(seg_d2), .seg_d3(seg_d3),
    .digit_en(digit_en), .lamp_test(lamp_test),
    .an(an), .seg(seg), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (pos=%0d)", tag, obs, exp, pos);
    end
  endtask

  // One clock edge; inputs were set at least 1 time unit earlier and are
  // still the sampled values when the outputs are compared.
  task automatic tick();
    int c, d;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      pos = 0;
      for (int i = 0; i < 4; i++) m_sh[i] = 7'h7F;
      m_en = 4'h0;
    end else begin
      if (pos == 0) begin
        m_sh[0] = seg_d0; m_sh[1] = seg_d1; m_sh[2] = seg_d2; m_sh[3] = seg_d3;
        m_en = digit_en;
      end
      pos = (pos + 1) % 32;
    end
    c = pos % 8;
    d = pos / 8;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_fs  = rst_n && (pos == 1);
    if (rst_n && c >= 2 && m_en[d]) begin
      e_an  = ~(4'b0001 << d);
      e_seg = lamp_test ? 7'h00 : m_sh[d];
    end
    chk("an", {3'b000, an}, {3'b000, e_an});
    chk("seg", seg, e_seg);
    chk("frame_start", {6'b0, frame_start}, {6'b0, e_fs});
    chk("one_anode", {6'b0, ($countones(~an) <= 1)}, 7'h01);
  endtask

  task automatic run_to(input int target);
    int n = 0;
    do begin
      tick();
      n++;
    end while (pos != target && n < 40);
    if (pos != target) chk("run_to", 7'(pos), 7'(target));
  endtask

  task automatic spot(input string tag, input logic [3:0] xa, input logic [6:0] xs, input logic xf);
    chk({tag, "_an"}, {3'b000, an}, {3'b000, xa});
    chk({tag, "_seg"}, seg, xs);
    chk({tag, "_fs"}, {6'b0, frame_start}, {6'b0, xf});
  endtask

  initial begin
    rst_n = 1'b0; lamp_test = 1'b0; digit_en = 4'hF;
    seg_d0 = 7'h08; seg_d1 = 7'h03; seg_d2 = 7'h46; seg_d3 = 7'h21;

    // Reset held for 5 cycles
    repeat (5) tick();
    spot("reset", 4'hF, 7'h7F, 1'b0);

    // Release: first edge latches and pulses frame_start; frame 1 scan order
    rst_n = 1'b1;
    tick();
    spot("first_latch", 4'hF, 7'h7F, 1'b1);
    tick();   spot("d0_drive", 4'hE, 7'h08, 1'b0);
    run_to(9);  spot("d1_blank", 4'hF, 7'h7F, 1'b0);
    run_to(10); spot("d1_drive", 4'hD, 7'h03, 1'b0);
    run_to(18); spot("d2_drive", 4'hB, 7'h46, 1'b0);
    run_to(26); spot("d3_drive", 4'h7, 7'h21, 1'b0);
    run_to(0);  spot("wrap_blank", 4'hF, 7'h7F, 1'b0);
    run_to(1);  spot("fs_recur", 4'hF, 7'h7F, 1'b1);

    // Frame consistency: changes mid-frame wait for the next latch
    run_to(4);
    seg_d1 = 7'h79;
    run_to(10); spot("d1_held", 4'hD, 7'h03, 1'b0);
    run_to(20);
    seg_d0 = 7'h12;
    run_to(31);
    run_to(2);  spot("d0_new", 4'hE, 7'h12, 1'b0);
    run_to(10); spot("d1_new", 4'hD, 7'h79, 1'b0);

    // Enable mask 0101, applied for the following frame
    digit_en = 4'b0101;
    run_to(2);  spot("mask_d0", 4'hE, 7'h12, 1'b0);
    run_to(12); spot("mask_d1", 4'hF, 7'h7F, 1'b0);
    run_to(20); spot("mask_d2", 4'hB, 7'h46, 1'b0);
    run_to(28); spot("mask_d3", 4'hF, 7'h7F, 1'b0);
    digit_en = 4'hF;

    // Lamp test is live, not shadowed, and never lights a blanked slot
    run_to(12);
    lamp_test = 1'b1;
    tick(); spot("lamp_on", 4'hD, 7'h00, 1'b0);
    lamp_test = 1'b0;
    tick(); spot("lamp_off", 4'hD, 7'h79, 1'b0);
    lamp_test = 1'b1;
    run_to(16); spot("lamp_blank", 4'hF, 7'h7F, 1'b0);
    run_to(18); spot("lamp_d2", 4'hB, 7'h00, 1'b0);
    lamp_test = 1'b0;
    tick(); spot("lamp_d2_off", 4'hB, 7'h46, 1'b0);

    // Reset mid-drive of digit 2, then restart with fresh inputs
    run_to(20);
    rst_n = 1'b0;
    seg_d0 = 7'h40;
    tick(); spot("mid_reset", 4'hF, 7'h7F, 1'b0);
    rst_n = 1'b1;
    tick(); spot("restart_latch", 4'hF, 7'h7F, 1'b1);
    tick(); spot("restart_d0", 4'hE, 7'h40, 1'b0);
    run_to(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Time-multiplexes four 7-segment digit patterns onto a shared common-anode 4-digit display. Sits directly downstream of the letter/rotor-position segment decoders: digit 0 carries the output letter, digits 1-3 carry rotor positions 0-2. Uses a refresh counter, a per-slot blanking interval to prevent ghosting, and frame-level shadow latching so all four digits shown in a frame come from the same input snapshot.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz digit rate at 100 MHz); must be ≥2.
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must satisfy 1 ≤ BLANK_CYCLES < REFRESH_DIV.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
rst_n  input  1  synchronous, active-low reset.
seg_d0  input  7  digit 0 pattern (letter), active-low, bit0=a … bit6=g.
seg_d1  input  7  digit 1 pattern (rotor 0 position), same encoding.
seg_d2  input  7  digit 2 pattern (rotor 1 position).
seg_d3  input  7  digit 3 pattern (rotor 2 position).
digit_en  input  4  per-digit enable; bit i=0 keeps digit i dark.
lamp_test  input  1  live override: all segments lit on enabled digits during drive.
an  output  4  anode selects, active-low; an[i]=0 lights digit i.
seg  output  7  segment cathodes, active-low, same bit order as seg_dN.
frame_start  output  1  one-cycle pulse: shadow registers were just reloaded.

Behaviour:
- Design has one clock (clk) and a synchronous, active-low reset (rst_n); there are no asynchronous paths.
- State: slot counter cnt (width $clog2(REFRESH_DIV)), digit index idx (2 bits), shadow patterns sh0..sh3 (7 bits each), shadow enable sh_en (4 bits).
- Reset (rst_n=0 at an edge): cnt=0, idx=0, sh0..sh3=7'h7F, sh_en=4'h0, an=4'hF, seg=7'h7F, frame_start=0. Reset applied at any point, including mid-drive, takes effect at that edge.
- Counting: each active edge, if cnt==REFRESH_DIV-1 then cnt←0 and idx←idx+1 (3 wraps to 0); otherwise cnt←cnt+1.
- Shadow latch: at any active edge where the current (cnt, idx)==(0, 0), sh0..sh3←seg_d0..seg_d3 and sh_en←digit_en. This includes the first edge after reset release. Inputs are ignored at all other edges.
- frame_start is registered. It is 1 exactly in the cycle where (cnt, idx)==(1, 0), i.e. the cycle right after a latch edge. Otherwise it is 0.
- Phase: BLANK when cnt < BLANK_CYCLES, DRIVE otherwise. The latch always happens in digit 0's BLANK phase, so a digit never changes while it is driven.
- an and seg are registered. Each is computed from the post-edge (cnt, idx), so the outputs correspond to the current cnt/idx with no extra lag.
- BLANK: an=4'hF, seg=7'h7F.
- DRIVE with sh_en[idx]=0: an=4'hF, seg=7'h7F.
- DRIVE with sh_en[idx]=1: an=~(4'b0001<<idx). seg=7'h00 if lamp_test=1, else sh[idx]. lamp_test is sampled live at each edge and is not shadowed.
- Scan period: 4×REFRESH_DIV cycles. Digit order 0,1,2,3. At most one anode is low at any time.

Test Plan:
(All with REFRESH_DIV=8, BLANK_CYCLES=2.)
1. Reset/startup: hold rst_n=0 for 5 cycles -> an=F, seg=7F, frame_start=0. Release -> frame_start=1 for exactly the one cycle after the first active edge, then recurs every 32 cycles.
2. Scan order: seg_d0..3=08,03,46,21, digit_en=F -> each 8-cycle slot shows 2 cycles of an=F/seg=7F then 6 cycles of an=E/seg=08, then D/03, B/46, 7/21. Period is 32 cycles, and an never has more than one zero bit.
3. Frame consistency: change seg_d0 to 7'h12 during digit 2 drive -> digit 0 still shows 08 for the rest of the frame and shows 12 only after the next frame_start.
4. Enable mask: digit_en=4'b0101 -> digit 1 and digit 3 slots show an=F/seg=7F for all 8 cycles, while digits 0 and 2 drive normally.
5. Lamp test: raise lamp_test mid-drive of digit 1 -> next cycle seg=00 with an=D. During BLANK, seg stays 7F. Drop lamp_test -> next cycle seg=03.
6. Reset mid-operation: rst_n=0 for one edge during digit 2 drive -> next cycle an=F, seg=7F, frame_start=0. After release, scanning restarts at digit 0 with freshly latched inputs.
